loom_axil_reg_slave: RTL and testbench

AXI-Lite subordinate that answers the transactions issued by the Loom socket BFM and other AXI-Lite masters. It holds a word-addressed scratch register file plus an interrupt register and a finish register. Its `irq_o` and `finish_o` outputs feed the master's interrupt and finish inputs, so it stands in for a DUT in loopback testbenches. Read and write channels run independently, with a configurable number of wait states.

---
 rtl/loom_axil_reg_slave.sv | 206 ++++++++++++++++++++
 tb/tb_loom_axil_reg_slave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loom_axil_reg_slave.sv
// AXI-Lite register slave: word-addressed scratch registers plus IRQ set/clear and a sticky finish flag.
// Read and write channels are independent FSMs, each with LATENCY wait cycles before its response.
module loom_axil_reg_slave #(
  parameter int ADDR_WIDTH = 20,
  parameter int N_REGS     = 16,
  parameter int N_IRQ      = 16,
  parameter int LATENCY    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic                  s_axil_arvalid_i,
  output logic                  s_axil_arready_o,
  output logic [31:0]           s_axil_rdata_o,
  output logic [1:0]            s_axil_rresp_o,
  output logic                  s_axil_rvalid_o,
  input  logic                  s_axil_rready_i,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic                  s_axil_awvalid_i,
  output logic                  s_axil_awready_o,
  input  logic [31:0]           s_axil_wdata_i,
  input  logic [3:0]            s_axil_wstrb_i,
  input  logic                  s_axil_wvalid_i,
  output logic                  s_axil_wready_o,
  output logic [1:0]            s_axil_bresp_o,
  output logic                  s_axil_bvalid_o,
  input  logic                  s_axil_bready_i,
  output logic [N_IRQ-1:0]      irq_o,
  output logic                  finish_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_SET = IW'(N_REGS);
  localparam logic [IW-1:0] IDX_CLR = IW'(N_REGS + 1);
  localparam logic [IW-1:0] IDX_FIN = IW'(N_REGS + 2);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {RdIdle, RdWait, RdResp} rd_state_e;
  typedef enum logic [1:0] {WrCollect, WrWait, WrResp} wr_state_e;

  rd_state_e rd_state;
  wr_state_e wr_state;
  logic [3:0] rd_cnt, wr_cnt;
  logic [IW-1:0] rd_idx_q, aw_idx_q;
  logic [31:0] rdata_q, wdata_q;
  logic [1:0] rresp_q, bresp_q;
  logic [3:0] wstrb_q;
  logic aw_held, w_held;
  logic [31:0] regs_q [N_REGS];
  logic [N_IRQ-1:0] irq_q;
  logic finish_q;

  logic [IW-1:0] rd_idx_c, wr_idx_c;
  logic [31:0] rd_data_c, wr_data_c;
  logic [1:0] rd_resp_c;
  logic [3:0] wr_strb_c;
  logic aw_take, w_take, wr_go, wr_commit, wr_decerr_c;

  // In idle the address is taken straight off the bus so LATENCY=0 can sample on the handshake edge.
  always_comb begin
    rd_idx_c = (rd_state == RdIdle) ? s_axil_araddr_i[ADDR_WIDTH-1:2] : rd_idx_q;
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (rd_idx_c > IDX_FIN) begin
      rd_resp_c = RESP_DECERR;
    end else if (rd_idx_c == IDX_SET || rd_idx_c == IDX_CLR) begin
      rd_data_c = 32'(irq_q);
    end else if (rd_idx_c == IDX_FIN) begin
      rd_data_c = {31'b0, finish_q};
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (rd_idx_c == IW'(k)) rd_data_c = regs_q[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state <= RdIdle;
      rd_cnt   <= '0;
      rd_idx_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        RdIdle: if (s_axil_arvalid_i) begin
          rd_idx_q <= rd_idx_c;
          if (LATENCY == 0) begin
            rd_state <= RdResp;
            rdata_q  <= rd_data_c;
            rresp_q  <= rd_resp_c;
          end else begin
            rd_state <= RdWait;
            rd_cnt   <= CNT_INIT;
          end
        end
        RdWait: if (rd_cnt == 4'd0) begin
          rd_state <= RdResp;
          rdata_q  <= rd_data_c;
          rresp_q  <= rd_resp_c;
        end else begin
          rd_cnt <= rd_cnt - 4'd1;
        end
        RdResp: if (s_axil_rready_i) rd_state <= RdIdle;
        default: rd_state <= RdIdle;
      endcase
    end
  end

  // Commit values come from the bus for whichever half is captured on this same edge.
  always_comb begin
    aw_take   = (wr_state == WrCollect) && !aw_held && s_axil_awvalid_i;
    w_take    = (wr_state == WrCollect) && !w_held && s_axil_wvalid_i;
    wr_go     = (wr_state == WrCollect) && (aw_held || aw_take) && (w_held || w_take);
    wr_idx_c  = (wr_state == WrCollect && !aw_held) ? s_axil_awaddr_i[ADDR_WIDTH-1:2] : aw_idx_q;
    wr_data_c = (wr_state == WrCollect && !w_held) ? s_axil_wdata_i : wdata_q;
    wr_strb_c = (wr_state == WrCollect && !w_held) ? s_axil_wstrb_i : wstrb_q;
    wr_commit = (wr_go && LATENCY == 0) || (wr_state == WrWait && wr_cnt == 4'd0);
    wr_decerr_c = wr_idx_c > IDX_FIN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state <= WrCollect;
      wr_cnt   <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        WrCollect: begin
          if (aw_take) begin
            aw_held  <= 1'b1;
            aw_idx_q <= s_axil_awaddr_i[ADDR_WIDTH-1:2];
          end
          if (w_take) begin
            w_held  <= 1'b1;
            wdata_q <= s_axil_wdata_i;
            wstrb_q <= s_axil_wstrb_i;
          end
          if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            if (LATENCY == 0) begin
              wr_state <= WrResp;
              bresp_q  <= wr_decerr_c ? RESP_DECERR : RESP_OKAY;
            end else begin
              wr_state <= WrWait;
              wr_cnt   <= CNT_INIT;
            end
          end
        end
        WrWait: if (wr_cnt == 4'd0) begin
          wr_state <= WrResp;
          bresp_q  <= wr_decerr_c ? RESP_DECERR : RESP_OKAY;
        end else begin
          wr_cnt <= wr_cnt - 4'd1;
        end
        WrResp: if (s_axil_bready_i) wr_state <= WrCollect;
        default: wr_state <= WrCollect;
      endcase
    end
  end

  // Control registers take the full word; scratch registers honour byte strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
      irq_q    <= '0;
      finish_q <= 1'b0;
    end else if (wr_commit) begin
      if (wr_idx_c == IDX_SET) begin
        irq_q <= irq_q | wr_data_c[N_IRQ-1:0];
      end else if (wr_idx_c == IDX_CLR) begin
        irq_q <= irq_q & ~wr_data_c[N_IRQ-1:0];
      end else if (wr_idx_c == IDX_FIN) begin
        if (wr_data_c[0]) finish_q <= 1'b1;
      end else begin
        for (int k = 0; k < N_REGS; k++) begin
          if (wr_idx_c == IW'(k)) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb_c[b]) regs_q[k][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign s_axil_arready_o = (rd_state == RdIdle);
  assign s_axil_rvalid_o  = (rd_state == RdResp);
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_awready_o = (wr_state == WrCollect) && !aw_held;
  assign s_axil_wready_o  = (wr_state == WrCollect) && !w_held;
  assign s_axil_bvalid_o  = (wr_state == WrResp);
  assign s_axil_bresp_o   = bresp_q;
  assign irq_o            = irq_q;
  assign finish_o         = finish_q;

endmodule

// File: tb/tb_loom_axil_reg_slave.sv
// Directed bench for loom_axil_reg_slave: a LATENCY=3 instance for most scenarios and a
// LATENCY=0 instance for back-to-back throughput.
module tb_loom_axil_reg_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] araddr = '0, awaddr = '0;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic arready, rvalid, awready, wready, bvalid, finish;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  logic [15:0] irq;

  logic [19:0] z_araddr = '0, z_awaddr = '0;
  logic z_arvalid = 1'b0, z_rready = 1'b0, z_awvalid = 1'b0, z_wvalid = 1'b0, z_bready = 1'b0;
  logic [31:0] z_wdata = '0;
  logic [3:0] z_wstrb = '0;
  logic z_arready, z_rvalid, z_awready, z_wready, z_bvalid, z_finish;
  logic [31:0] z_rdata;
  logic [1:0] z_rresp, z_bresp;
  logic [15:0] z_irq;

  int total = 0;
  int bad = 0;

  loom_axil_reg_slave #(.ADDR_WIDTH(20), .N_REGS(16), .N_IRQ(16), .LATENCY(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
    .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .irq_o(irq), .finish_o(finish)
  );

  loom_axil_reg_slave #(.ADDR_WIDTH(20), .N_REGS(16), .N_IRQ(16), .LATENCY(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axil_araddr_i(z_araddr), .s_axil_arvalid_i(z_arvalid), .s_axil_arready_o(z_arready),
    .s_axil_rdata_o(z_rdata), .s_axil_rresp_o(z_rresp), .s_axil_rvalid_o(z_rvalid), .s_axil_rready_i(z_rready),
    .s_axil_awaddr_i(z_awaddr), .s_axil_awvalid_i(z_awvalid), .s_axil_awready_o(z_awready),
    .s_axil_wdata_i(z_wdata), .s_axil_wstrb_i(z_wstrb), .s_axil_wvalid_i(z_wvalid), .s_axil_wready_o(z_wready),
    .s_axil_bresp_o(z_bresp), .s_axil_bvalid_o(z_bvalid), .s_axil_bready_i(z_bready),
    .irq_o(z_irq), .finish_o(z_finish)
  );

  // Latency is counted in cycles from the handshake edge to the edge raising bvalid, plus one.
  task automatic axi_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int n;
    logic pa, pw;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      pa = awvalid && awready;
      pw = wvalid && wready;
      @(posedge clk); #1;
      if (pa) awvalid = 1'b0;
      if (pw) wvalid = 1'b0;
      n++;
      if (awvalid || wvalid) @(negedge clk);
    end
    lat = 1;
    @(negedge clk);
    while (!bvalid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!bvalid) begin
      total++; bad++;
      $display("[TB] FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [19:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rvalid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!rvalid) begin
      total++; bad++;
      $display("[TB] FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
    end
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({arready, awready, wready} !== 3'b111) begin bad++; $display("[TB] FAIL reset_readies: got %b required 111", {arready, awready, wready}); end
    total++; if ({rvalid, bvalid, finish} !== 3'b000) begin bad++; $display("[TB] FAIL reset_valids: got %b required 000", {rvalid, bvalid, finish}); end
    total++; if (irq !== 16'h0 || rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_payload: irq=%h rdata=%h rresp=%b bresp=%b required zeros", irq, rdata, rresp, bresp); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(20'h004, 32'hDEADBEEF, 4'hF, r, lat);
    total++; if (r !== 2'b00) begin bad++; $display("[TB] FAIL wr_resp: got %b required 00", r); end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL wr_latency: got %0d required 4", lat); end
    axi_read(20'h004, d, r, lat);
    total++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin bad++; $display("[TB] FAIL rd_full: got %h/%b required deadbeef/00", d, r); end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL rd_latency: got %0d required 4", lat); end
    axi_write(20'h004, 32'h11223344, 4'b0101, r, lat);
    axi_read(20'h004, d, r, lat);
    total++; if (d !== 32'hDE22BE44) begin bad++; $display("[TB] FAIL rd_strobe: got %h required de22be44", d); end
    axi_read(20'h007, d, r, lat);
    total++; if (d !== 32'hDE22BE44 || r !== 2'b00) begin bad++; $display("[TB] FAIL rd_low_bits_ignored: got %h/%b required de22be44/00", d, r); end
  endtask

  // One channel handshakes first; the other follows two edges later.
  task automatic test_ordering(input bit w_first, input logic [19:0] a, input logic [31:0] d);
    int lat;
    logic [31:0] rd; logic [1:0] r;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF;
    if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    total++; if ((w_first ? wready : awready) !== 1'b0) begin bad++; $display("[TB] FAIL order_held_ready w_first=%0d: got 1 required 0", w_first); end
    @(negedge clk);
    if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bvalid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 4 || bvalid !== 1'b1) begin bad++; $display("[TB] FAIL order_latency w_first=%0d: got %0d required 4", w_first, lat); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(a, rd, r, lat);
    total++; if (rd !== d) begin bad++; $display("[TB] FAIL order_readback w_first=%0d: got %h required %h", w_first, rd, d); end
  endtask

  task automatic test_decerr();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_read(20'h04C, d, r, lat);
    total++; if (r !== 2'b11 || d !== 32'h0) begin bad++; $display("[TB] FAIL rd_decerr: got %h/%b required 0/11", d, r); end
    axi_read(20'h0FC, d, r, lat);
    total++; if (r !== 2'b11) begin bad++; $display("[TB] FAIL rd_decerr_far: got %b required 11", r); end
    axi_write(20'h04C, 32'hFFFFFFFF, 4'hF, r, lat);
    total++; if (r !== 2'b11) begin bad++; $display("[TB] FAIL wr_decerr: got %b required 11", r); end
    axi_read(20'h004, d, r, lat);
    total++; if (d !== 32'hDE22BE44) begin bad++; $display("[TB] FAIL decerr_no_change r1: got %h required de22be44", d); end
    axi_read(20'h000, d, r, lat);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL decerr_no_change r0: got %h required 0", d); end
    total++; if (irq !== 16'h0 || finish !== 1'b0) begin bad++; $display("[TB] FAIL decerr_no_ctrl: irq=%h finish=%b required 0/0", irq, finish); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(20'h040, 32'h00000005, 4'hF, r, lat);
    total++; if (irq !== 16'h0005 || r !== 2'b00) begin bad++; $display("[TB] FAIL irq_set: got %h/%b required 0005/00", irq, r); end
    axi_write(20'h044, 32'h00000001, 4'hF, r, lat);
    total++; if (irq !== 16'h0004) begin bad++; $display("[TB] FAIL irq_clr: got %h required 0004", irq); end
    axi_read(20'h040, d, r, lat);
    total++; if (d !== 32'h00000004 || r !== 2'b00) begin bad++; $display("[TB] FAIL irq_read_set: got %h/%b required 00000004/00", d, r); end
    axi_write(20'h040, 32'h00010010, 4'h0, r, lat);
    total++; if (irq !== 16'h0014) begin bad++; $display("[TB] FAIL irq_set_nostrb: got %h required 0014", irq); end
    axi_read(20'h044, d, r, lat);
    total++; if (d !== 32'h00000014) begin bad++; $display("[TB] FAIL irq_read_clr: got %h required 00000014", d); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] d; logic [1:0] r; int lat;
    @(negedge clk);
    araddr = 20'h004; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 30) begin @(negedge clk); n++; end
    araddr = 20'h008; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (rvalid !== 1'b1 || rdata !== 32'hDE22BE44 || rresp !== 2'b00 || arready !== 1'b0) begin
        bad++; $display("[TB] FAIL rd_hold cyc=%0d: rvalid=%b rdata=%h arready=%b required 1/de22be44/0", i, rvalid, rdata, arready);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    total++; if (arready !== 1'b1) begin bad++; $display("[TB] FAIL rd_ar_after_r: got %b required 1", arready); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 30) begin @(negedge clk); n++; end
    total++; if (rvalid !== 1'b1 || rdata !== 32'hA5A50001) begin bad++; $display("[TB] FAIL rd_second: got %h required a5a50001", rdata); end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    awaddr = 20'h00C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 30) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        bad++; $display("[TB] FAIL wr_hold cyc=%0d: bvalid=%b bresp=%b aw/w ready=%b%b required 1/00/00", i, bvalid, bresp, awready, wready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(20'h00C, d, r, lat);
    total++; if (d !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL wr_hold_readback: got %h required 0badf00d", d); end
  endtask

  task automatic test_finish_reset();
    int n;
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(20'h048, 32'h00000000, 4'hF, r, lat);
    total++; if (finish !== 1'b0) begin bad++; $display("[TB] FAIL finish_zero_write: got %b required 0", finish); end
    axi_write(20'h048, 32'h00000001, 4'h0, r, lat);
    total++; if (finish !== 1'b1) begin bad++; $display("[TB] FAIL finish_set: got %b required 1", finish); end
    axi_write(20'h048, 32'h00000000, 4'hF, r, lat);
    axi_read(20'h048, d, r, lat);
    total++; if (finish !== 1'b1 || d !== 32'h1) begin bad++; $display("[TB] FAIL finish_sticky: finish=%b read=%h required 1/00000001", finish, d); end
    axi_write(20'h000, 32'h12345678, 4'hF, r, lat);
    axi_read(20'h000, d, r, lat);
    total++; if (d !== 32'h12345678) begin bad++; $display("[TB] FAIL reg0_before_reset: got %h required 12345678", d); end
    @(negedge clk);
    araddr = 20'h000; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 30) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0 || finish !== 1'b0 || irq !== 16'h0 || arready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_mid_read: rvalid=%b finish=%b irq=%h arready=%b required 0/0/0000/1", rvalid, finish, irq, arready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(20'h000, d, r, lat);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("[TB] FAIL reg0_after_reset: got %h/%b required 0/00", d, r); end
  endtask

  // LATENCY=0 instance with valids and readies held high: one transfer every two cycles.
  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    z_awaddr = 20'h004; z_wdata = 32'hCAFEF00D; z_wstrb = 4'hF;
    z_awvalid = 1'b1; z_wvalid = 1'b1; z_bready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (z_bvalid && z_bready) begin
        cnt++;
        total++; if (z_bresp !== 2'b00) begin bad++; $display("[TB] FAIL b2b_bresp: got %b required 00", z_bresp); end
      end
      @(negedge clk);
    end
    z_awvalid = 1'b0; z_wvalid = 1'b0; z_bready = 1'b0;
    total++; if (cnt !== 5) begin bad++; $display("[TB] FAIL b2b_writes: got %0d required 5", cnt); end
    @(negedge clk);
    z_araddr = 20'h004; z_arvalid = 1'b1; z_rready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (z_rvalid && z_rready) begin
        cnt++;
        total++; if (z_rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL b2b_rdata: got %h required cafef00d", z_rdata); end
      end
      @(negedge clk);
    end
    z_arvalid = 1'b0; z_rready = 1'b0;
    total++; if (cnt !== 5) begin bad++; $display("[TB] FAIL b2b_reads: got %0d required 5", cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ordering(1'b1, 20'h008, 32'hA5A50001);
    test_ordering(1'b0, 20'h010, 32'h5A5A7777);
    test_decerr();
    test_irq();
    test_backpressure();
    test_finish_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
